// File: rtl/riscv_core_mem_arbiter.sv
// riscv_core_mem_arbiter: shares one memory port between the instruction
// fetch path and the data load/store path. Requests pass straight through to
// memory. An in-order tag FIFO records the owner of each outstanding
// transaction, and each response is routed back to that owner.
// Optional feature macro: RISCV_MEMARB_ROUND_ROBIN_EN (alternating priority).
// When it is undefined, D always wins arbitration.
module riscv_core_mem_arbiter #(
   parameter int p_depth = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ireq_val,
   output logic                       ireq_rdy,
   input  logic [31:0]                ireq_msg_addr,
   input  logic                       dreq_val,
   output logic                       dreq_rdy,
   input  logic                       dreq_msg_type,
   input  logic [31:0]                dreq_msg_addr,
   input  logic [1:0]                 dreq_msg_len,
   input  logic [31:0]                dreq_msg_data,
   output logic                       iresp_val,
   input  logic                       iresp_rdy,
   output logic [31:0]                iresp_msg_data,
   output logic                       dresp_val,
   input  logic                       dresp_rdy,
   output logic [31:0]                dresp_msg_data,
   output logic                       memreq_val,
   input  logic                       memreq_rdy,
   output logic                       memreq_msg_type,
   output logic [31:0]                memreq_msg_addr,
   output logic [1:0]                 memreq_msg_len,
   output logic [31:0]                memreq_msg_data,
   input  logic                       memresp_val,
   output logic                       memresp_rdy,
   input  logic [31:0]                memresp_msg_data,
   output logic [$clog2(p_depth):0]   outstanding
);

   localparam int AW = $clog2(p_depth);
   localparam int CW = AW + 1;

   logic [p_depth-1:0] r_tags;   // 0 = I, 1 = D
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_rptr;
   logic [CW-1:0]      r_count;

   logic w_full, w_empty, w_head;
   logic w_prio_d, w_grant_d, w_grant_i;
   logic w_push, w_pop;

   assign w_full  = (r_count == CW'(p_depth));
   assign w_empty = (r_count == '0);
   assign w_head  = r_tags[r_rptr];

`ifdef RISCV_MEMARB_ROUND_ROBIN_EN
   logic r_prio_d;

   // The requester that was just served drops to low priority
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_prio_d <= 1'b1;
      else if (w_push) r_prio_d <= ~w_grant_d;
   end

   assign w_prio_d = r_prio_d;
`else
   assign w_prio_d = 1'b1;
`endif

   assign w_grant_d = dreq_val && (!ireq_val || w_prio_d);
   assign w_grant_i = ireq_val && !w_grant_d;

   // Request path: the winner's fields go straight to memory
   assign memreq_val      = (ireq_val || dreq_val) && !w_full;
   assign memreq_msg_type = w_grant_d ? dreq_msg_type : 1'b0;
   assign memreq_msg_addr = w_grant_d ? dreq_msg_addr : ireq_msg_addr;
   assign memreq_msg_len  = w_grant_d ? dreq_msg_len  : 2'd0;
   assign memreq_msg_data = w_grant_d ? dreq_msg_data : 32'd0;
   assign ireq_rdy        = w_grant_i && !w_full && memreq_rdy;
   assign dreq_rdy        = w_grant_d && !w_full && memreq_rdy;

   // Response path: steered by the oldest outstanding tag
   assign memresp_rdy    = !w_empty && (w_head ? dresp_rdy : iresp_rdy);
   assign iresp_val      = memresp_val && !w_empty && !w_head;
   assign dresp_val      = memresp_val && !w_empty &&  w_head;
   assign iresp_msg_data = memresp_msg_data;
   assign dresp_msg_data = memresp_msg_data;

   // Full blocks memreq_val, so a push never happens when full
   assign w_push = memreq_val && memreq_rdy;
   assign w_pop  = memresp_val && memresp_rdy;

   // Tag FIFO storage and pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tags <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_tags[r_wptr] <= w_grant_d;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
   end

   // Occupancy: a simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_count <= '0;
      else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign outstanding = r_count;

endmodule

// File: doc/riscv_core_mem_arbiter.md
# riscv_core_mem_arbiter

Two-requester arbiter that shares one memory port between the instruction fetch path and the data load/store path of the 5-stage RISCV core. It forwards one request per cycle with zero added latency. It records which requester owns each outstanding transaction in an in-order tag FIFO, and routes each memory response back to its owner. It sits between the core's `imemreq`/`dmemreq` ports and a single-ported memory or cache.

## Interface
Parameters:
- `p_depth`, default 4: maximum outstanding transactions (tag FIFO depth). Must be a power of two and at least 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `ireq_val` in 1 / `ireq_rdy` out 1 / `ireq_msg_addr` in 32: instruction request. It is always a 4-byte read.
- `dreq_val` in 1 / `dreq_rdy` out 1: data request handshake.
- `dreq_msg_type` in 1: 0 = read, 1 = write.
- `dreq_msg_addr` in 32 / `dreq_msg_len` in 2 / `dreq_msg_data` in 32: data request payload. For `len`, 0 encodes 4 bytes.
- `iresp_val` out 1 / `iresp_rdy` in 1 / `iresp_msg_data` out 32: instruction response.
- `dresp_val` out 1 / `dresp_rdy` in 1 / `dresp_msg_data` out 32: data response.
- `memreq_val` out 1 / `memreq_rdy` in 1: memory request handshake.
- `memreq_msg_type` out 1 / `memreq_msg_addr` out 32 / `memreq_msg_len` out 2 / `memreq_msg_data` out 32: memory request payload.
- `memresp_val` in 1 / `memresp_rdy` out 1 / `memresp_msg_data` in 32: memory response.
- `outstanding` out $clog2(p_depth)+1: current tag FIFO occupancy.

## Operation
- **Handshake:** every transfer is val/rdy. A transfer fires when val && rdy are both high in the same cycle.
- **Tag FIFO:** 1-bit tags, 0 = I and 1 = D. It uses a write pointer, a read pointer and a count register. Pointers wrap modulo `p_depth`.
- **Full / empty:** `full` = (count == `p_depth`); `empty` = (count == 0).
- **Grant (combinational):**
  - `grant_d` = `dreq_val` && (!`ireq_val` || `prio_d`).
  - `grant_i` = `ireq_val` && !`grant_d`.
  - Without the round-robin feature, `prio_d` = 1.
- **Request forwarding:**
  - `memreq_val` = (`ireq_val` || `dreq_val`) && !`full`.
  - `memreq_msg_*` takes the granted requester's fields. On an I grant the fields are type = 0, len = 0, data = 0.
  - `ireq_rdy` = `grant_i` && !`full` && `memreq_rdy`.
  - `dreq_rdy` = `grant_d` && !`full` && `memreq_rdy`.
  - The losing requester sees rdy = 0.
- **Push:** on a `memreq` fire, push the grant's tag. Increment the write pointer.
- **Response routing (combinational, by head tag):**
  - `memresp_rdy` = !`empty` && (head ? `dresp_rdy` : `iresp_rdy`).
  - `iresp_val` = `memresp_val` && !`empty` && head == 0.
  - `dresp_val` = `memresp_val` && !`empty` && head == 1.
  - Both response data outputs carry `memresp_msg_data` unmodified.
- **Pop:** on a `memresp` fire, pop one tag. Increment the read pointer.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Full boundary:** when `full`, no request is accepted, even if a pop occurs the same cycle.
- **Empty boundary:** when `empty`, `memresp_rdy` = 0 and any `memresp_val` is ignored. A response without a matching request is a protocol violation by the memory.
- **Writes:** write requests also receive a response. The response data is don't-care but must still be popped.

## Timing
- Request path: 0-cycle combinational pass-through from requester to memory.
- Response path: 0-cycle combinational pass-through from memory to requester.
- A tag pushed in cycle N is visible at the FIFO head in cycle N+1. The memory must not respond before cycle N+1, so the minimum round trip is 1 cycle.
- Throughput: one request and one response per cycle, sustained.
- On `reset` assertion (asynchronous):
  - count = 0, both pointers = 0, `prio_d` = 1, `outstanding` = 0.
  - `memresp_rdy`, `iresp_val` and `dresp_val` go 0 immediately.
  - Request rdy and val outputs follow their inputs (combinational); with count = 0 no request is blocked by `full`.
- Reset mid-operation: all outstanding tags are discarded. The memory must be reset in the same cycle; in-flight responses are lost.
- Requesters may deassert val only after their transfer fires. The arbiter never retracts a grant while the corresponding `memreq_rdy` is low, provided the requester vals are stable.

## Configuration
- Macro `RISCV_MEMARB_ROUND_ROBIN_EN`.
- When defined:
  - `prio_d` is a register. It is set to 0 after a D request fires and set to 1 after an I request fires.
  - Under continuous contention, grants therefore alternate D, I, D, I, …
  - Reset value of `prio_d` is 1, so D wins first.
- When undefined: `prio_d` is constant 1 and D always wins. Fixed priority makes forward progress for loads and stores guaranteed while fetch stalls.

## Test plan
- **Single fetch:** `ireq` addr 0x00080000 with `memreq_rdy` = 1 → `memreq` type 0, addr 0x00080000. Next cycle, `memresp` data 0x00000013 → `iresp_val` = 1 with data 0x00000013, `dresp_val` = 0, `outstanding` 1→0.
- **Contention, fixed priority:** `ireq_val` = `dreq_val` = 1 for 4 cycles, memory always ready → 4 D grants, `ireq_rdy` = 0 throughout. With the macro defined → grant order D, I, D, I.
- **Full:** `p_depth` = 4, memory withholds responses, 6 back-to-back fetches → exactly 4 accepted, `outstanding` = 4, `memreq_val` = 0. One response arrives → a fifth request is accepted in the following cycle, not the same cycle.
- **In-order routing:** issue I, D (write, data 0xDEADBEEF), I → `memreq_msg_data` = 0xDEADBEEF on the D request. Responses A, B, C are delivered to `iresp`, `dresp`, `iresp` in that order.
- **Backpressure:** head tag is D, `dresp_rdy` = 0, `memresp_val` = 1 → `memresp_rdy` = 0 and count holds. `dresp_rdy` = 1 → pop occurs in that cycle.
- **Async reset:** assert `reset` mid-cycle with `outstanding` = 3 → `outstanding` = 0 and `memresp_rdy` = 0 before the next clock edge.
